// File: rtl/ahb_pixel_pkg.sv
// Shared types and constants for the AHB pixel memory responder.
package ahb_pixel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    RESP,
    GAP
  } state_t;

  localparam int          PIX_W         = 24;
  localparam logic [7:0]  HRDATA_PAD    = 8'h00;
  localparam logic [31:0] LAST_ADDR_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/pixel_ram.sv
// Single-port synchronous pixel RAM, read-first, one-cycle read latency.
module pixel_ram
  import ahb_pixel_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ahb_pixel_mem_responder.sv
// Memory-side responder for the accelerator master bus, with a host
// backdoor that has priority on the shared RAM port.
module ahb_pixel_mem_responder
  import ahb_pixel_pkg::*;
#(
  parameter int DEPTH       = 65536,
  parameter int AW          = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      m_haddr,
  input  logic             m_hwrite,
  input  logic [31:0]      m_hwdata,
  output logic             m_hready,
  output logic [31:0]      m_hrdata,
  input  logic             bd_en,
  input  logic             bd_we,
  input  logic [AW-1:0]    bd_addr,
  input  logic [PIX_W-1:0] bd_wdata,
  output logic [PIX_W-1:0] bd_rdata,
  output logic [31:0]      wr_count,
  output logic [31:0]      first_waddr,
  output logic             oob_err
);

  state_t           state;
  logic [3:0]       cnt;
  logic [31:0]      lat_addr;
  logic [31:0]      last_addr;
  logic             lat_wr;
  logic             lat_oob;
  logic             pend;
  logic [PIX_W-1:0] wbuf;
  logic [31:0]      hrdata_q;
  logic             bd_rd_q;
  logic [PIX_W-1:0] bd_hold;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [PIX_W-1:0] ram_wdata;
  logic [PIX_W-1:0] ram_rdata;
  logic [PIX_W-1:0] rd_px;
  logic             acc_commit;
  logic             unused_hwdata;

  assign unused_hwdata = ^m_hwdata[31:24];

  assign acc_commit = !rst && lat_wr && !lat_oob &&
                      ((state == RESP) || (state == GAP && pend));

  // Backdoor wins the port; a deferred write commits from wbuf in GAP.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = lat_addr[AW-1:0];
    ram_wdata = m_hwdata[PIX_W-1:0];
    if (bd_en) begin
      ram_we    = bd_we;
      ram_addr  = bd_addr;
      ram_wdata = bd_wdata;
    end else if (acc_commit) begin
      ram_we    = 1'b1;
      ram_wdata = (state == GAP) ? wbuf : m_hwdata[PIX_W-1:0];
    end
  end

  pixel_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign rd_px    = lat_oob ? '0 : ram_rdata;
  assign m_hrdata = (state == RESP && !lat_wr) ?
                    {rd_px, HRDATA_PAD} : hrdata_q;
  assign bd_rdata = bd_rd_q ? ram_rdata : bd_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      bd_rd_q <= 1'b0;
      bd_hold <= '0;
    end else begin
      bd_rd_q <= bd_en && !bd_we;
      if (bd_rd_q) bd_hold <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      lat_oob     <= 1'b0;
      pend        <= 1'b0;
      wbuf        <= '0;
      last_addr   <= LAST_ADDR_RST;
      m_hready    <= 1'b0;
      hrdata_q    <= '0;
      wr_count    <= '0;
      first_waddr <= '0;
      oob_err     <= 1'b0;
    end else begin
      m_hready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m_hwrite || m_haddr != last_addr) begin
            lat_addr <= m_haddr;
            lat_wr   <= m_hwrite;
            lat_oob  <= m_haddr >= 32'(DEPTH);
            cnt      <= 4'(WAIT_STATES);
            state    <= (WAIT_STATES == 0) ? RD : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RD;
        end
        RD: begin
          if (!bd_en) begin
            m_hready <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          last_addr <= lat_addr;
          oob_err   <= oob_err | lat_oob;
          if (!lat_wr) hrdata_q <= {rd_px, HRDATA_PAD};
          if (lat_wr) begin
            wbuf <= m_hwdata[PIX_W-1:0];
            pend <= !lat_oob && bd_en;
            if (wr_count == '0) first_waddr <= lat_addr;
            if (wr_count != '1) wr_count <= wr_count + 32'd1;
          end
          state <= GAP;
        end
        GAP: begin
          if (!(pend && bd_en)) begin
            pend  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
